imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction memory before the processor runs. It accepts a byte stream with a valid/ready handshake, reads a 4-byte little-endian word-count header, assembles the following bytes into little-endian 32-bit instructions, and issues one write per word to the instruction memory write port at byte addresses 0, 4, 8, … It sits between the host/UART byte source and the instruction memory. It holds the CPU in reset until loading completes.

## Interface

- `SIZE`, 64, instruction memory depth in 32-bit words; writes beyond it are suppressed.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- `rx_valid`  in  1  byte-source data valid.
- `rx_data`  in  8  byte from the source.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on a cycle where `rx_valid & rx_ready`.
- `mem_we`  out  1  instruction memory write enable, one-cycle pulse per word.
- `mem_addr`  out  32  byte address of the write, always a multiple of 4.
- `mem_data`  out  32  instruction word being written.
- `busy`  out  1  high in HDR and DATA.
- `done`  out  1  high in DONE.
- `error`  out  1  header count exceeded `SIZE`; sticky until the next accepted `start` or reset.
- `cpu_hold`  out  1  keeps the processor in reset; high except in DONE.

## Operation

- States: IDLE, HDR, DATA, DONE.
- IDLE + `start` -> HDR. Clear the byte counter, word counter and `error`.
- HDR: accept 4 bytes into count N as little-endian (first byte = N[7:0]). On the 4th byte:
  - N = 0 -> DONE.
  - Otherwise -> DATA.
  - If N > `SIZE`, set `error`.
- DATA: accept bytes into a shift register, first byte = word[7:0]. On the 4th byte of word k (k from 0):
  - If k < `SIZE`, register `mem_data` = word and `mem_addr` = 4·k, and pulse `mem_we`.
  - If k ≥ `SIZE`, discard the word; `mem_we` stays 0.
  - After word N-1, go to DONE.
- DONE + `start` -> HDR (reload). `start` in HDR or DATA is ignored.
- `rx_ready` = 1 exactly in HDR and DATA. There is no backpressure from memory; the memory accepts a write every cycle.
- Gaps in `rx_valid` are allowed anywhere; partial words and the partial header are retained across gaps.
- Counters: the byte-in-word counter is 2 bits and wraps 3 -> 0. The word counter is 32 bits. N is 32 bits, unsigned compare.
- Reset mid-load returns to IDLE. Memory contents already written are left as-is; there is no erase.

## Timing

- Reset values:
  - state IDLE.
  - `rx_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_data` 0.
  - `busy` 0, `done` 0, `error` 0, `cpu_hold` 1.
- `start` sampled in cycle t -> `busy` = 1 and `rx_ready` = 1 in t+1.
- Write latency: 4th byte of a word accepted in cycle t -> `mem_we` = 1 with valid `addr`/`data` in cycle t+1 only. `mem_addr`/`mem_data` hold their last values otherwise.
- Last data byte accepted in cycle t:
  - `rx_ready` = 0 from t+1.
  - Final `mem_we` in t+1.
  - `done` = 1 and `cpu_hold` = 0 from t+1 (state changes on the same edge as the write is registered).
- N = 0: 4th header byte in cycle t -> `done` = 1 in t+1, no write.
- `error` rises in the cycle after the 4th header byte.
- Back-to-back bytes: sustained 1 byte/cycle; one word written every 4 cycles.
- `start` and reset asserted together: reset wins.

## Test plan

- Reset: hold `reset_n` = 0 for 2 cycles with `rx_valid` = 1 -> all outputs at reset values, `cpu_hold` = 1, no byte consumed.
- Basic load: `start`, then bytes 02 00 00 00, 13 05 A0 00, 93 05 B0 00 at 1 byte/cycle -> exactly two writes:
  - 0x00A00513 at addr 0x0.
  - 0x00B00593 at addr 0x4, each 1 cycle after its 4th byte.
  - `done` = 1 and `cpu_hold` = 0 in the same cycle as the second write.
- Gapped stream: same payload with `rx_valid` dropped for 3 cycles between every byte -> identical writes and values; no write before the 4th byte of each word.
- Empty program: header 00 00 00 00 -> no `mem_we`; `done` = 1 one cycle after the 4th header byte; `rx_ready` = 0 thereafter.
- Overflow with `SIZE` = 4: header 06 00 00 00 plus 24 data bytes -> `error` = 1 after the header; writes at 0x0–0xC only; all 24 bytes consumed; then `done`.
- Reset mid-DATA after 2 of 3 words, then `start` with a new 1-word load -> state restarts at HDR; new word written at 0x0; `error` = 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Fills the instruction memory from a byte stream before the CPU runs.
//   A 4-byte little-endian word count N is read first, then N little-endian
//   32-bit words are written to byte addresses 0, 4, 8, ... Words whose index
//   is SIZE or more are consumed but not written. The CPU is held in reset
//   until the load completes.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   start     one-cycle load request, honoured in IDLE or DONE
//   rx_valid  byte source valid
//   rx_data   byte from the source
//   rx_ready  loader accepts a byte (HDR or DATA)
//   mem_we    one-cycle write pulse per stored word
//   mem_addr  byte address of the write (multiple of 4)
//   mem_data  instruction word being written
//   busy      high while reading header or data
//   done      high once loading finished
//   error     header count exceeded SIZE (sticky until next start/reset)
//   cpu_hold  keeps the CPU in reset, low only in DONE
module imem_loader #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] n_q, n_d;
  logic [31:0] shift_q, shift_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        error_q, error_d;

  logic        accept;
  logic [31:0] assembled;

  assign accept    = rx_valid & rx_ready;
  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign assembled = {rx_data, shift_q[31:8]};

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    n_d        = n_q;
    shift_d    = shift_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HDR;
          bcnt_d  = 2'd0;
          wcnt_d  = 32'd0;
          error_d = 1'b0;
        end
      end
      S_HDR: begin
        if (accept) begin
          shift_d = assembled;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            n_d     = assembled;
            error_d = (assembled > SIZE_W);
            state_d = (assembled == 32'd0) ? S_DONE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = assembled;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Words past the memory depth are drained but never written.
            if (wcnt_q < SIZE_W) begin
              mem_we_d   = 1'b1;
              mem_addr_d = {wcnt_q[29:0], 2'b00};
              mem_data_d = assembled;
            end
            wcnt_d = wcnt_q + 32'd1;
            if (wcnt_q == n_q - 32'd1) begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bcnt_q     <= 2'd0;
      wcnt_q     <= 32'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_data_q <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      error_q    <= error_d;
    end
  end

  // Assembly registers are always fully rewritten before use.
  always_ff @(posedge clk) begin
    n_q     <= n_d;
    shift_q <= shift_d;
  end

  assign rx_ready = (state_q == S_HDR) || (state_q == S_DATA);
  assign busy     = rx_ready;
  assign done     = (state_q == S_DONE);
  assign cpu_hold = (state_q != S_DONE);
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader (SIZE = 4): directed loads with literal expectations
// plus randomized loads, all checked every cycle against a byte-count model.
module tb_imem_loader;

  localparam int SIZE = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, busy, done, error, cpu_hold;
  logic [31:0] mem_addr, mem_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_loader #(.SIZE(SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a load is a count of bytes accepted since start; the header is
  // bytes 0..3, data byte i belongs to word (i-4)/4 at lane (i-4)%4.
  bit          m_active;
  longint      m_nb;
  logic [31:0] m_n, m_word, m_addr, m_data;
  bit          m_we, m_err;
  bit          m_rdy;
  longint      m_k, m_j;

  function automatic longint m_total();
    return 4 + 4 * longint'({32'b0, m_n});
  endfunction

  function automatic bit m_ready();
    return m_active && (m_nb < 4 || m_nb < m_total());
  endfunction

  function automatic bit m_done();
    return m_active && m_nb >= 4 && m_nb == m_total();
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active = 0; m_nb = 0; m_n = 0; m_word = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
    end else begin
      m_rdy = m_ready();
      m_we  = 0;
      if (start && !m_rdy) begin
        m_active = 1; m_nb = 0; m_n = 0; m_err = 0;
      end else if (m_rdy && rx_valid) begin
        if (m_nb < 4) begin
          m_n[8*int'(m_nb) +: 8] = rx_data;
          if (m_nb == 3) m_err = (m_n > 32'(SIZE));
        end else begin
          m_k = (m_nb - 4) / 4;
          m_j = (m_nb - 4) % 4;
          m_word[8*int'(m_j) +: 8] = rx_data;
          if (m_j == 3 && m_k < SIZE) begin
            m_we = 1; m_addr = 32'(4 * m_k); m_data = m_word;
          end
        end
        m_nb++;
      end
    end
  end

  always @(negedge clk) begin
    chk("rx_ready", rx_ready, m_ready());
    chk("busy", busy, m_ready());
    chk("done", done, m_done());
    chk("cpu_hold", cpu_hold, !m_done());
    chk("error", error, m_err);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_data", mem_data, m_data);
  end

  int          wr_cnt = 0;
  logic [31:0] last_addr = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      last_addr = mem_addr;
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: rx_ready stayed 0 for %0d cycles, required 1", t);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int g);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (g > 0 && i < 3) gap(g);
    end
  endtask

  logic [31:0] rn;
  int          nbytes, abort_at;

  initial begin
    // Reset held with a byte offered.
    reset_n  = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    rx_valid = 1'b0;
    reset_n  = 1'b1;
    gap(2);

    // Basic back-to-back load.
    do_start();
    chk("start_busy", busy, 1);
    chk("start_rx_ready", rx_ready, 1);
    send_word(32'h0000_0002, 0);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0);
    chk("basic_no_early_we", mem_we, 0);
    send_byte(8'h00);
    chk("basic_w0_we", mem_we, 1);
    chk("basic_w0_addr", mem_addr, 32'h0);
    chk("basic_w0_data", mem_data, 32'h00A00513);
    send_word(32'h00B00593, 0);
    chk("basic_w1_we", mem_we, 1);
    chk("basic_w1_addr", mem_addr, 32'h4);
    chk("basic_w1_data", mem_data, 32'h00B00593);
    chk("model_pin_data", m_data, 32'h00B00593);
    chk("basic_done", done, 1);
    chk("basic_cpu_hold", cpu_hold, 0);
    @(negedge clk);
    chk("basic_after_ready", rx_ready, 0);
    chk("basic_after_we", mem_we, 0);
    chk("basic_hold_data", mem_data, 32'h00B00593);

    // Gapped stream, reload from DONE.
    do_start();
    send_word(32'h0000_0002, 3);
    gap(3);
    send_word(32'h00A00513, 3);
    chk("gap_w0_addr", mem_addr, 32'h0);
    chk("gap_w0_data", mem_data, 32'h00A00513);
    gap(3);
    send_word(32'h00B00593, 3);
    chk("gap_w1_we", mem_we, 1);
    chk("gap_w1_data", mem_data, 32'h00B00593);
    chk("gap_done", done, 1);

    // Empty program.
    do_start();
    wr_cnt = 0;
    send_word(32'h0, 0);
    chk("empty_done", done, 1);
    chk("empty_we", mem_we, 0);
    chk("empty_rx_ready", rx_ready, 0);
    #1;
    chk("empty_writes", wr_cnt, 0);

    // Overflow: 6 words into a 4-word memory.
    @(negedge clk);
    do_start();
    wr_cnt = 0;
    send_word(32'h0000_0006, 0);
    chk("ovf_error", error, 1);
    for (int w = 0; w < 6; w++) send_word(32'h1111_0000 + 32'(w), 0);
    #1;
    chk("ovf_writes", wr_cnt, 4);
    chk("ovf_last_addr", last_addr, 32'hC);
    chk("ovf_done", done, 1);
    chk("ovf_data", mem_data, 32'h1111_0003);
    @(negedge clk);

    // Reset mid-DATA, then a fresh one-word load.
    do_start();
    send_word(32'h0000_0003, 0);
    send_word(32'hAAAA_0001, 0);
    send_word(32'hAAAA_0002, 0);
    pulse_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_hold", cpu_hold, 1);
    do_start();
    send_word(32'h0000_0001, 0);
    send_word(32'hEFBE_ADDE, 0);
    chk("midrst_we", mem_we, 1);
    chk("midrst_addr", mem_addr, 32'h0);
    chk("midrst_data", mem_data, 32'hEFBEADDE);
    chk("midrst_error", error, 0);
    chk("midrst_done", done, 1);

    // Randomized loads; the per-cycle compare does the checking.
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      do_start();
      if ($urandom_range(0, 5) == 0) rn = $urandom | 32'h0100_0000;
      else                           rn = 32'($urandom_range(0, 7));
      abort_at = ($urandom_range(0, 9) == 0 || rn > 8) ? int'($urandom_range(0, 10)) : -1;
      send_word(rn, $urandom_range(0, 1));
      nbytes = (rn > 8) ? 12 : 4 * int'(rn);
      for (int b = 0; b < nbytes; b++) begin
        if (b == abort_at) break;
        if ($urandom_range(0, 7) == 0) do_start();
        send_byte(8'($urandom));
        gap($urandom_range(0, 2));
      end
      if (abort_at >= 0) pulse_reset();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
